// File: rtl/contador_vidas_pkg.sv
// Shared definitions for the life counter: state encoding and default parameters.
package contador_vidas_pkg;

   typedef enum logic [1:0] {
      VIVO         = 2'd0,
      INVULNERAVEL = 2'd1,
      FIM          = 2'd2
   } estado_t;

   localparam int DEF_WIDTH      = 3;
   localparam int DEF_MAX_VIDAS  = 7;
   localparam int DEF_INIT_VIDAS = 7;
   localparam int DEF_COOLDOWN   = 4;

endpackage

// File: rtl/contador_cooldown.sv
// Loadable down-counter with enable; done is high while the count sits at zero.
module contador_cooldown #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         done
);

   logic [W-1:0] count_q, count_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/contador_vidas_param.sv
// Saturating life counter with post-hit invulnerability window and absorbing game-over state.
module contador_vidas_param
   import contador_vidas_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int MAX_VIDAS  = DEF_MAX_VIDAS,
   parameter int INIT_VIDAS = DEF_INIT_VIDAS,
   parameter int COOLDOWN   = DEF_COOLDOWN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             hit,
   input  logic             bonus,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] vidas,
   output logic             game_over,
   output logic             invulneravel,
   output logic             vida_perdida
);

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VIDAS);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VIDAS);
   localparam int               CD_W   = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
   // The hit edge itself is the first invulnerable cycle, so the timer holds one less.
   localparam logic [CD_W-1:0]  CD_LOAD = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

   estado_t          estado_q, estado_d;
   logic [WIDTH-1:0] vidas_q, vidas_d;
   logic             game_over_q, game_over_d;
   logic             invul_q, invul_d;
   logic             perdida_q, perdida_d;
   logic             cd_load, cd_en, cd_done;
   logic [CD_W-1:0]  cd_val;

   contador_cooldown #(.W(CD_W)) u_cooldown (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (cd_en),
      .load       (cd_load),
      .load_value (cd_val),
      .done       (cd_done)
   );

   always_comb begin
      estado_d  = estado_q;
      vidas_d   = vidas_q;
      perdida_d = 1'b0;
      cd_load   = 1'b0;
      cd_en     = 1'b0;
      cd_val    = '0;
      if (enable) begin
         if (load) begin
            vidas_d  = (load_value > MAX_V) ? MAX_V : load_value;
            estado_d = (vidas_d == '0) ? FIM : VIVO;
            cd_load  = 1'b1;
         end else begin
            unique case (estado_q)
               VIVO: begin
                  if (hit && !bonus && (vidas_q != '0)) begin
                     vidas_d   = vidas_q - 1'b1;
                     perdida_d = 1'b1;
                     if (vidas_d == '0) begin
                        estado_d = FIM;
                     end else if (COOLDOWN > 0) begin
                        estado_d = INVULNERAVEL;
                        cd_load  = 1'b1;
                        cd_val   = CD_LOAD;
                     end
                  end else if (bonus && !hit && (vidas_q < MAX_V)) begin
                     vidas_d = vidas_q + 1'b1;
                  end
               end
               INVULNERAVEL: begin
                  if (bonus && (vidas_q < MAX_V)) begin
                     vidas_d = vidas_q + 1'b1;
                  end
                  if (cd_done) begin
                     estado_d = VIVO;
                  end else begin
                     cd_en = 1'b1;
                  end
               end
               FIM: begin
               end
               default: estado_d = VIVO;
            endcase
         end
      end
      game_over_d = (estado_d == FIM);
      invul_d     = (estado_d == INVULNERAVEL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= VIVO;
         vidas_q     <= INIT_V;
         game_over_q <= 1'b0;
         invul_q     <= 1'b0;
         perdida_q   <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         vidas_q     <= vidas_d;
         game_over_q <= game_over_d;
         invul_q     <= invul_d;
         perdida_q   <= perdida_d;
      end
   end

   assign vidas        = vidas_q;
   assign game_over    = game_over_q;
   assign invulneravel = invul_q;
   assign vida_perdida = perdida_q;

endmodule

// File: tb/tb_contador_vidas_param.sv
// Directed scenarios plus randomized stimulus, checked every cycle against a behavioural model.
module tb_contador_vidas_param;

   localparam int WIDTH    = 3;
   localparam int MAXV     = 7;
   localparam int INITV    = 7;
   localparam int COOLDOWN = 4;

   localparam int S_VIVO = 0;
   localparam int S_INV  = 1;
   localparam int S_FIM  = 2;

   typedef struct {
      int vidas;
      int st;
      int rem;
      bit pulse;
   } model_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable, hit, bonus, load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] vidas;
   logic             game_over, invulneravel, vida_perdida;

   int     checks   = 0;
   int     failures = 0;
   bit     chk_en   = 1'b0;
   model_t m;

   contador_vidas_param #(
      .WIDTH(WIDTH), .MAX_VIDAS(MAXV), .INIT_VIDAS(INITV), .COOLDOWN(COOLDOWN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .hit          (hit),
      .bonus        (bonus),
      .load         (load),
      .load_value   (load_value),
      .vidas        (vidas),
      .game_over    (game_over),
      .invulneravel (invulneravel),
      .vida_perdida (vida_perdida)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic model_t reset_model();
      model_t r;
      r.vidas = INITV;
      r.st    = S_VIVO;
      r.rem   = 0;
      r.pulse = 1'b0;
      return r;
   endfunction

   // One enabled edge of the game rules, expressed as remaining-cycle arithmetic.
   function automatic model_t step(input model_t c, input bit h, input bit b,
                                   input bit l, input int lv, input bit e);
      model_t n = c;
      n.pulse = 1'b0;
      if (!e) return n;
      if (l) begin
         n.vidas = (lv > MAXV) ? MAXV : lv;
         n.st    = (n.vidas == 0) ? S_FIM : S_VIVO;
         n.rem   = 0;
         return n;
      end
      case (c.st)
         S_VIVO: begin
            if (h && !b) begin
               n.vidas = c.vidas - 1;
               n.pulse = 1'b1;
               if (n.vidas == 0) begin
                  n.st = S_FIM;
               end else if (COOLDOWN > 0) begin
                  n.st  = S_INV;
                  n.rem = COOLDOWN;
               end
            end else if (b && !h) begin
               n.vidas = (c.vidas + 1 > MAXV) ? MAXV : c.vidas + 1;
            end
         end
         S_INV: begin
            if (b) n.vidas = (c.vidas + 1 > MAXV) ? MAXV : c.vidas + 1;
            n.rem = c.rem - 1;
            if (n.rem == 0) n.st = S_VIVO;
         end
         default: begin
         end
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= reset_model();
      else        m <= step(m, hit, bonus, load, int'(load_value), enable);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_vidas", int'(vidas), m.vidas);
         check("cmp_game_over", int'(game_over), int'(m.st == S_FIM));
         check("cmp_invulneravel", int'(invulneravel), int'(m.st == S_INV));
         check("cmp_vida_perdida", int'(vida_perdida), int'(m.pulse));
      end
   end

   task automatic drive(input bit h, input bit b, input bit l, input int lv, input bit e);
      hit        = h;
      bonus      = b;
      load       = l;
      load_value = WIDTH'(lv);
      enable     = e;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1);
   endtask

   task automatic async_reset_pulse();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_vidas", int'(vidas), 7);
      check("rst_async_invul", int'(invulneravel), 0);
      check("rst_async_game_over", int'(game_over), 0);
      check("rst_async_pulse", int'(vida_perdida), 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      int invcnt;
      rst_n = 1'b1;
      hit = 0; bonus = 0; load = 0; load_value = '0; enable = 1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_vidas", int'(vidas), 7);
      check("reset_game_over", int'(game_over), 0);
      check("reset_invul", int'(invulneravel), 0);
      check("reset_pulse", int'(vida_perdida), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Seven spaced hits drain every life.
      pulses = 0;
      for (int k = 1; k <= 7; k++) begin
         drive(1, 0, 0, 0, 1);
         check("r031_vidas", int'(vidas), 7 - k);
         if (vida_perdida) pulses++;
         for (int i = 0; i < 5; i++) begin
            idle(1);
            if (vida_perdida) pulses++;
         end
      end
      check("r031_pulses", pulses, 7);
      check("r031_game_over", int'(game_over), 1);

      // FIM is absorbing until a nonzero load.
      drive(1, 0, 0, 0, 1);
      drive(0, 1, 0, 0, 1);
      drive(1, 1, 0, 0, 1);
      check("r034_fim_vidas", int'(vidas), 0);
      check("r034_fim_go", int'(game_over), 1);
      drive(0, 0, 1, 3, 1);
      check("r034_load3_vidas", int'(vidas), 3);
      check("r034_load3_go", int'(game_over), 0);
      drive(0, 0, 1, 0, 1);
      check("r034_load0_go", int'(game_over), 1);
      drive(0, 0, 1, 7, 1);
      check("r034_load7_vidas", int'(vidas), 7);

      // Hit held through the invulnerability window.
      drive(1, 0, 0, 0, 1);
      check("r032_first_hit", int'(vidas), 6);
      invcnt = invulneravel ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 1);
         if (invulneravel) invcnt++;
      end
      check("r032_invul_cycles", invcnt, 4);
      check("r032_vidas_held", int'(vidas), 6);
      drive(1, 0, 0, 0, 1);
      check("r032_next_hit", int'(vidas), 5);
      idle(5);

      // Saturation and hit/bonus cancellation.
      drive(0, 0, 1, 7, 1);
      drive(0, 1, 0, 0, 1);
      check("r033_bonus_sat", int'(vidas), 7);
      drive(1, 1, 0, 0, 1);
      check("r033_cancel_vidas", int'(vidas), 7);
      check("r033_cancel_pulse", int'(vida_perdida), 0);
      check("r033_cancel_invul", int'(invulneravel), 0);

      // Enable low freezes the cooldown.
      drive(1, 0, 0, 0, 1);
      idle(1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0);
         check("r035_frozen_invul", int'(invulneravel), 1);
      end
      idle(1);
      check("r035_resume1", int'(invulneravel), 1);
      idle(1);
      check("r035_resume2", int'(invulneravel), 1);
      idle(1);
      check("r035_resume3", int'(invulneravel), 0);

      // Asynchronous reset between edges while invulnerable.
      drive(1, 0, 0, 0, 1);
      check("r036_pre_invul", int'(invulneravel), 1);
      idle(1);
      async_reset_pulse();
      drive(1, 0, 0, 0, 1);
      check("r036_after_hit", int'(vidas), 6);

      // Randomized play checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset_pulse();
         end else begin
            drive($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 4, int'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 85);
         end
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
